// File: rtl/fp_round_pkg.sv
// Shared rounding-mode encodings and format helpers for the fp_round_pipe rounding unit.
package fp_round_pkg;

    typedef logic [1:0] rnd_mode_t;

    localparam rnd_mode_t RM_RNE = 2'b00;  // nearest, ties to even
    localparam rnd_mode_t RM_RTZ = 2'b01;  // toward zero
    localparam rnd_mode_t RM_RUP = 2'b10;  // toward +inf
    localparam rnd_mode_t RM_RDN = 2'b11;  // toward -inf

    // All-ones biased exponent (inf/NaN encoding) for an exp_w-bit field.
    function automatic logic [31:0] exp_all_ones(input int exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

    // Exponent of the largest finite value.
    function automatic logic [31:0] max_finite_exp(input int exp_w);
        return exp_all_ones(exp_w) - 32'd1;
    endfunction

    // Fraction of the largest finite value (all ones, up to 63 bits).
    function automatic logic [63:0] max_finite_frac(input int man_w);
        return (64'd1 << man_w) - 64'd1;
    endfunction

    // True when rounding overflow in this mode/sign saturates to infinity rather than max finite.
    function automatic logic overflow_to_inf(input rnd_mode_t mode, input logic sign);
        logic r;
        r = 1'b0;
        case (mode)
            RM_RNE:  r = 1'b1;
            RM_RTZ:  r = 1'b0;
            RM_RUP:  r = !sign;
            RM_RDN:  r = sign;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fp_round_incr.sv
// Stage-1 increment decision: whether the truncated significand is bumped by one ulp.
module fp_round_incr
    import fp_round_pkg::*;
(
    input  rnd_mode_t mode,
    input  logic      sign,
    input  logic      lsb,
    input  logic      g,
    input  logic      r,
    input  logic      s,
    output logic      inc
);

    logic any;

    assign any = g | r | s;

    always_comb begin
        // NOTE: default first so every path assigns inc and no latch is inferred.
        inc = 1'b0;
        case (mode)
            RM_RNE:  inc = g & (r | s | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = !sign && any;
            RM_RDN:  inc = sign && any;
            default: inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 rounding pipeline with valid/ready flow control.
// Define FP_ROUND_FLAGS_EN to add the registered out_inexact/out_overflow flag outputs.
module fp_round_pipe
    import fp_round_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W+3:0] in_man,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_man
`ifdef FP_ROUND_FLAGS_EN
    ,
    output logic             out_inexact,
    output logic             out_overflow
`endif
);

    localparam logic [EXP_W:0]   EXP_ONES  = (EXP_W+1)'(exp_all_ones(EXP_W));
    localparam logic [EXP_W:0]   EXP_MAXF  = (EXP_W+1)'(max_finite_exp(EXP_W));
    localparam logic [EXP_W:0]   EXP_ONE   = (EXP_W+1)'(1);
    localparam logic [MAN_W-1:0] FRAC_MAXF = MAN_W'(max_finite_frac(MAN_W));

    // ---------------- handshake ----------------
    logic s1_valid;
    logic s2_advance;

    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;

    // ---------------- stage 1: increment decision ----------------
    logic [MAN_W:0]   sig;
    logic             in_special;
    logic             inc_raw;
    logic             inc;
    logic [MAN_W+1:0] sig_r_n;

    assign sig        = in_man[MAN_W+3:3];
    assign in_special = ({1'b0, in_exp} == EXP_ONES);

    fp_round_incr u_incr (
        .mode (rnd_mode_t'(in_mode)),
        .sign (in_sign),
        .lsb  (sig[0]),
        .g    (in_man[2]),
        .r    (in_man[1]),
        .s    (in_man[0]),
        .inc  (inc_raw)
    );

    // Inf/NaN payloads must never be disturbed by rounding.
    assign inc     = inc_raw && !in_special;
    assign sig_r_n = {1'b0, sig} + (MAN_W+2)'(inc);

    logic             s1_sign;
    logic [EXP_W-1:0] s1_exp;
    logic [MAN_W+1:0] s1_sig_r;
    rnd_mode_t        s1_mode;
    logic             s1_special;
`ifdef FP_ROUND_FLAGS_EN
    logic             s1_any;
`endif

    // NOTE: payload registers carry no reset; s1_valid alone qualifies them, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_sign    <= in_sign;
            s1_exp     <= in_exp;
            s1_sig_r   <= sig_r_n;
            s1_mode    <= rnd_mode_t'(in_mode);
            s1_special <= in_special;
`ifdef FP_ROUND_FLAGS_EN
            s1_any     <= |in_man[2:0];
`endif
        end
    end

    // ---------------- stage 2: renormalise / saturate ----------------
    logic             carry;
    logic [EXP_W:0]   exp_n;
    logic [MAN_W-1:0] frac_n;
    logic             ovf_n;

    assign carry = s1_sig_r[MAN_W+1];

    always_comb begin
        exp_n  = {1'b0, s1_exp};
        frac_n = s1_sig_r[MAN_W-1:0];
        ovf_n  = 1'b0;
        if (!s1_special) begin
            if (carry) begin
                exp_n  = {1'b0, s1_exp} + EXP_ONE;
                frac_n = s1_sig_r[MAN_W:1];
            end else if (s1_exp == '0 && s1_sig_r[MAN_W]) begin
                // Subnormal rounded up into the smallest normal binade.
                exp_n = EXP_ONE;
            end
            ovf_n = (exp_n >= EXP_ONES);
        end
        if (ovf_n) begin
            if (overflow_to_inf(s1_mode, s1_sign)) begin
                exp_n  = EXP_ONES;
                frac_n = '0;
            end else begin
                exp_n  = EXP_MAXF;
                frac_n = FRAC_MAXF;
            end
        end
    end

    // ---------------- pipeline control and output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
            s1_valid     <= 1'b0;
            out_valid    <= 1'b0;
            out_sign     <= 1'b0;
            out_exp      <= '0;
            out_man      <= '0;
`ifdef FP_ROUND_FLAGS_EN
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
`endif
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s2_advance) begin
                out_valid <= s1_valid;
            end
            if (s2_advance && s1_valid) begin
                out_sign     <= s1_sign;
                out_exp      <= exp_n[EXP_W-1:0];
                out_man      <= frac_n;
`ifdef FP_ROUND_FLAGS_EN
                out_inexact  <= s1_any && !s1_special;
                out_overflow <= ovf_n;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Directed self-checking bench for fp_round_pipe (binary32 configuration).
module tb_fp_round_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_man;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_man;
`ifdef FP_ROUND_FLAGS_EN
    logic        out_inexact;
    logic        out_overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11;

    fp_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_man       (in_man),
        .in_mode      (in_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_man      (out_man)
`ifdef FP_ROUND_FLAGS_EN
        ,
        .out_inexact  (out_inexact),
        .out_overflow (out_overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // One isolated beat: presented, then checked for two-cycle latency and result.
    task automatic run_one(input string tag, input logic sign, input logic [7:0] e,
                           input logic [23:0] sig, input logic [2:0] grs, input logic [1:0] mode,
                           input logic [7:0] want_exp, input logic [22:0] want_man,
                           input logic want_inx, input logic want_ovf);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sign   = sign;
        in_exp    = e;
        in_man    = {sig, grs};
        in_mode   = mode;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sign"}, 32'(out_sign), 32'(sign));
        check({tag, "_exp"}, 32'(out_exp), 32'(want_exp));
        check({tag, "_man"}, 32'(out_man), 32'(want_man));
`ifdef FP_ROUND_FLAGS_EN
        check({tag, "_inexact"}, 32'(out_inexact), 32'(want_inx));
        check({tag, "_overflow"}, 32'(out_overflow), 32'(want_ovf));
`else
        if (want_inx === 1'bx || want_ovf === 1'bx) $display("note: flag expectations unused in this build");
`endif
    endtask

    // Eight-beat stream; beat i: exp 0x40+i, sig 0x800000|(i<<4), RNE, GRS=110 for odd i (rounds up), 010 for even.
    task automatic run_stream(input string tag, input int stall_start, input int stall_len,
                              output int last_rx);
        int sent;
        int rcvd;
        sent    = 0;
        rcvd    = 0;
        last_rx = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 8);
            in_sign   = 1'b0;
            in_exp    = 8'h40 + 8'(sent);
            in_man    = {24'h800000 | 24'(sent << 4), ((sent % 2) == 1) ? 3'b110 : 3'b010};
            in_mode   = RNE;
            out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            #1;
            if (stall_len > 0 && cyc == stall_start + stall_len - 1) begin
                check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
                check({tag, "_stall_out_valid"}, 32'(out_valid), 32'd1);
            end
            if (out_valid && out_ready) begin
                check({tag, "_exp"}, 32'(out_exp), 32'h40 + 32'(rcvd));
                check({tag, "_man"}, 32'(out_man), 32'((rcvd << 4) + (rcvd % 2)));
                rcvd++;
                last_rx = cyc;
            end
            if (in_valid && in_ready) sent++;
            if (rcvd == 8) break;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_beats_received"}, 32'(rcvd), 32'd8);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_man    = '0;
        in_mode   = RNE;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_sign", 32'(out_sign), 32'd0);
        check("reset_out_exp", 32'(out_exp), 32'd0);
        check("reset_out_man", 32'(out_man), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        //       tag           sign  exp    sig         grs     mode  out_exp out_man      inx   ovf
        run_one("rne_tie_odd",  1'b0, 8'h80, 24'h800001, 3'b100, RNE, 8'h80, 23'h000002, 1'b1, 1'b0);
        run_one("rne_tie_even", 1'b0, 8'h80, 24'h800000, 3'b100, RNE, 8'h80, 23'h000000, 1'b1, 1'b0);
        run_one("rne_above",    1'b0, 8'h80, 24'h800000, 3'b101, RNE, 8'h80, 23'h000001, 1'b1, 1'b0);
        run_one("rne_carry",    1'b0, 8'h7F, 24'hFFFFFF, 3'b110, RNE, 8'h80, 23'h000000, 1'b1, 1'b0);
        run_one("rtz_carry",    1'b0, 8'h7F, 24'hFFFFFF, 3'b110, RTZ, 8'h7F, 23'h7FFFFF, 1'b1, 1'b0);
        run_one("rne_ovf",      1'b0, 8'hFE, 24'hFFFFFF, 3'b100, RNE, 8'hFF, 23'h000000, 1'b1, 1'b1);
        run_one("rtz_ovf",      1'b0, 8'hFE, 24'hFFFFFF, 3'b100, RTZ, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0);
        run_one("rdn_neg_ovf",  1'b1, 8'hFE, 24'hFFFFFF, 3'b100, RDN, 8'hFF, 23'h000000, 1'b1, 1'b1);
        run_one("rup_neg_ovf",  1'b1, 8'hFE, 24'hFFFFFF, 3'b100, RUP, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0);
        run_one("rup_subnorm",  1'b0, 8'h00, 24'h7FFFFF, 3'b110, RUP, 8'h01, 23'h000000, 1'b1, 1'b0);
        run_one("rup_exact",    1'b0, 8'h10, 24'h812345, 3'b000, RUP, 8'h10, 23'h012345, 1'b0, 1'b0);
        run_one("rup_sticky",   1'b0, 8'h10, 24'h812345, 3'b001, RUP, 8'h10, 23'h012346, 1'b1, 1'b0);
        run_one("rdn_pos",      1'b0, 8'h10, 24'h812345, 3'b111, RDN, 8'h10, 23'h012345, 1'b1, 1'b0);
        run_one("rdn_neg",      1'b1, 8'h10, 24'h812345, 3'b001, RDN, 8'h10, 23'h012346, 1'b1, 1'b0);
        run_one("inf_pass",     1'b0, 8'hFF, 24'h800000, 3'b100, RNE, 8'hFF, 23'h000000, 1'b0, 1'b0);

        // Full-rate stream: beat 7 presented in cycle 7 must appear in cycle 9.
        run_stream("stream", 100, 0, last);
        check("stream_last_cycle", 32'(last), 32'd9);

        // Stream with five cycles of downstream backpressure starting at cycle 3.
        run_stream("bp", 3, 5, last);
        check("bp_last_cycle", 32'(last), 32'd14);

        // Reset while beats are in flight: nothing may emerge afterwards.
        @(negedge clk);
        in_valid  = 1'b1;
        in_exp    = 8'h20;
        in_man    = {24'h900000, 3'b000};
        in_mode   = RTZ;
        out_ready = 1'b1;
        @(negedge clk);
        in_exp = 8'h21;
        rst    = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_flush_out_valid", 32'(out_valid), 32'd0);
        check("rst_flush_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_flush_no_pulse", 32'(out_valid), 32'd0);
        end

        run_one("nan_pass",     1'b0, 8'hFF, 24'hC00000, 3'b111, RUP, 8'hFF, 23'h400000, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
